// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one hex display among four requesters; grants a fixed dwell
// and snapshots the winner's word. Grant lands 1 cycle after request; no backpressure from the display.
module hex_display_arbiter #(
  parameter int HOLD_W      = 24,
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_req,
  input  logic [63:0] i_data,
  output logic [3:0]  o_gnt,
  output logic [3:0]  o_done,
  output logic        o_busy,
  output logic [15:0] o_data
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        done_q, done_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic       withdraw;
  logic       expire;

  // Search starts just past the previous winner, so a holder only wins again when alone.
  always_comb begin
    logic [1:0] cand;
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_vld && i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign withdraw = ~|(i_req & gnt_q);
  assign expire   = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SHOW;
          gnt_d   = 4'b0001 << win_idx;
          data_d  = i_data[16*win_idx +: 16];
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (withdraw || expire) begin
          // A requester dropping on its final dwell cycle forfeits the done pulse.
          if (expire && !withdraw) begin
            done_d = gnt_q;
          end
          if (win_vld) begin
            state_d = SHOW;
            gnt_d   = 4'b0001 << win_idx;
            data_d  = i_data[16*win_idx +: 16];
            last_d  = win_idx;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      data_q  <= 16'h0000;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_done = done_q;
  assign o_busy = (state_q == SHOW);
  assign o_data = data_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with a 4-cycle dwell.
module tb_hex_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [63:0] i_data;
  logic [3:0]  o_gnt;
  logic [3:0]  o_done;
  logic        o_busy;
  logic [15:0] o_data;

  int n_chk  = 0;
  int n_pass = 0;

  hex_display_arbiter #(.HOLD_W(24), .HOLD_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_data (i_data),
    .o_gnt  (o_gnt),
    .o_done (o_done),
    .o_busy (o_busy),
    .o_data (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    i_req  = 4'b0000;
    i_data = 64'h0;
    #12;
    chk("rst_gnt",  32'(o_gnt),  32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    rst_n = 1'b1;

    // Single requester; holding req through expiry refreshes, dropping after done withdraws.
    i_req = 4'b0001;
    i_data[15:0] = 16'h1234;
    tick();
    chk("single_gnt",  32'(o_gnt),  32'h1);
    chk("single_data", 32'(o_data), 32'h1234);
    chk("single_busy", 32'(o_busy), 32'h1);
    repeat (3) tick();
    chk("single_hold", 32'(o_gnt),  32'h1);
    chk("single_nodn", 32'(o_done), 32'h0);
    tick();
    chk("single_done", 32'(o_done), 32'h1);
    i_req = 4'b0000;
    tick();
    chk("single_idle_gnt",  32'(o_gnt),  32'h0);
    chk("single_idle_busy", 32'(o_busy), 32'h0);
    chk("single_idle_done", 32'(o_done), 32'h0);
    chk("single_idle_data", 32'(o_data), 32'h1234);

    // Round robin from a fresh pointer: 0,1,2,3,0 with no idle gap.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    i_req  = 4'b1111;
    i_data = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt",  32'(o_gnt),  32'(4'b0001 << (g % 4)));
      chk("rr_data", 32'(o_data), 32'h000A + 32'(g % 4));
      chk("rr_busy", 32'(o_busy), 32'h1);
      chk("rr_done", 32'(o_done), (g == 0) ? 32'h0 : 32'(4'b0001 << ((g + 3) % 4)));
      repeat (3) tick();
      chk("rr_hold",   32'(o_gnt),  32'(4'b0001 << (g % 4)));
      chk("rr_nodone", 32'(o_done), 32'h0);
    end
    // Drop on the expiry cycle: withdrawal wins, no done.
    i_req = 4'b0000;
    tick();
    chk("rr_exp_wd_gnt",  32'(o_gnt),  32'h0);
    chk("rr_exp_wd_done", 32'(o_done), 32'h0);

    // Snapshot: requester 2 word frozen while its input changes.
    i_req = 4'b0100;
    i_data[47:32] = 16'hBEEF;
    i_data[63:48] = 16'h3333;
    tick();
    chk("snap_gnt",  32'(o_gnt),  32'h4);
    chk("snap_data", 32'(o_data), 32'hBEEF);
    i_data[47:32] = 16'h0000;
    i_req = 4'b1100;
    repeat (3) tick();
    chk("snap_hold", 32'(o_data), 32'hBEEF);
    tick();
    chk("snap_done", 32'(o_done), 32'h4);
    chk("snap_next", 32'(o_gnt),  32'h8);
    chk("snap_ndat", 32'(o_data), 32'h3333);
    i_req = 4'b0000;
    tick();
    chk("snap_idle", 32'(o_gnt), 32'h0);

    // Withdrawal: requester 1 drops at dwell cycle 2 while 3 is pending.
    i_req = 4'b0010;
    i_data[31:16] = 16'h0B0B;
    i_data[63:48] = 16'h0D0D;
    tick();
    chk("wd_gnt1", 32'(o_gnt), 32'h2);
    i_req = 4'b1010;
    repeat (2) tick();
    i_req = 4'b1000;
    tick();
    chk("wd_gnt3", 32'(o_gnt),  32'h8);
    chk("wd_done", 32'(o_done), 32'h0);
    chk("wd_data", 32'(o_data), 32'h0D0D);
    i_req = 4'b0000;
    tick();
    chk("wd_idle", 32'(o_busy), 32'h0);

    // Sole-requester refresh picks up new data at expiry.
    i_req = 4'b0100;
    i_data[47:32] = 16'h1111;
    tick();
    chk("ref_gnt",  32'(o_gnt),  32'h4);
    chk("ref_data", 32'(o_data), 32'h1111);
    i_data[47:32] = 16'h2222;
    repeat (3) tick();
    chk("ref_old",  32'(o_data), 32'h1111);
    tick();
    chk("ref_done", 32'(o_done), 32'h4);
    chk("ref_regn", 32'(o_gnt),  32'h4);
    chk("ref_new",  32'(o_data), 32'h2222);
    i_req = 4'b0000;
    tick();
    chk("ref_idle", 32'(o_gnt), 32'h0);

    // Asynchronous reset mid-dwell.
    i_req = 4'b0001;
    i_data[15:0] = 16'h5555;
    tick();
    chk("ar_gnt", 32'(o_gnt), 32'h1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt0",  32'(o_gnt),  32'h0);
    chk("ar_busy0", 32'(o_busy), 32'h0);
    chk("ar_done0", 32'(o_done), 32'h0);
    chk("ar_data0", 32'(o_data), 32'h0);
    i_req = 4'b1010;
    @(negedge clk);
    chk("ar_hold", 32'(o_gnt), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ar_first", 32'(o_gnt),  32'h2);
    chk("ar_fdat",  32'(o_data), 32'h0B0B);
    chk("ar_fdone", 32'(o_done), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares one 4-digit hex_display between four requesters; sits directly upstream of the display's i_data input.
- Grants the display round-robin for a fixed dwell time per grant.
- Snapshots the granted requester's 16-bit word and signals completion back to that requester.

Parameters:
- HOLD_W, 24, width of the dwell counter.
- HOLD_CYCLES, 12000000, dwell length in clk cycles per grant; legal range 1 to 2^HOLD_W-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_req  input  4  per-requester request, level; held high until o_done or voluntary withdrawal
- i_data  input  64  requester words; requester k drives bits [16k+15:16k]
- o_gnt  output  4  one-hot grant, all zero when idle
- o_done  output  4  one-cycle pulse to requester k when its dwell completes
- o_busy  output  1  high while any grant is active
- o_data  output  16  word for hex_display i_data

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state:
  - State = IDLE; o_gnt = 0; o_done = 0; o_busy = 0; o_data = 16'h0000.
  - Round-robin pointer last = 3, so requester 0 has first priority.
  - Dwell counter = 0.
- Reset mid-dwell aborts immediately to the reset state. No o_done pulse is issued.
- States: IDLE, SHOW. All outputs are registered.
- Arbitration function: search i_req starting at (last+1) mod 4 and wrapping; the first set bit wins.
- IDLE:
  - If i_req != 0, the next edge enters SHOW and sets o_gnt to the winner.
  - The same edge sets o_data = i_data slice of the winner, last = winner, and counter = 0.
  - Latency from i_req rising to o_gnt: 1 cycle. o_busy = 1 in SHOW.
- SHOW, normal dwell:
  - Counter increments each cycle.
  - o_data stays frozen at the snapshot; changes on i_data during the dwell are ignored.
- SHOW, dwell expiry (counter == HOLD_CYCLES-1):
  - The next edge pulses o_done[granted] for exactly one cycle.
  - The same edge re-arbitrates.
- Re-arbitration at expiry:
  - If any request is pending, go to SHOW with the new winner. New snapshot, counter = 0, no idle gap.
  - The round-robin order ensures the previous holder wins only if it is the sole requester. In that case it is re-granted and its data is re-snapshotted (refresh).
  - If no request is pending, go to IDLE with o_gnt = 0, o_busy = 0.
- The requester must drop i_req in the cycle after seeing o_done unless it wants another turn.
- Withdrawal: if i_req[granted] = 0 during SHOW before expiry, the next edge aborts the grant.
  - No o_done pulse.
  - Same re-arbitration as expiry, excluding nothing.
- Expiry and withdrawal in the same cycle: treated as withdrawal, so no o_done pulse.
- o_data retains the last snapshot in IDLE; the display keeps showing it.
- HOLD_CYCLES = 1: every grant lasts exactly one cycle, with o_done each cycle.
- Requests arriving during a dwell are held pending (level-sensitive). There is no starvation: each requester waits at most 3 dwells.

Test Plan:
- Reset / single requester (HOLD_CYCLES=4): reset, check all outputs zero and o_data=0000. Raise i_req=0001 with i_data[15:0]=1234 → o_gnt=0001 after 1 cycle and o_data=1234. o_done[0] pulses 4 cycles after grant, then IDLE (i_req dropped).
- Round-robin: i_req=1111 held with words 000A/000B/000C/000D → grants 0,1,2,3,0 back-to-back, each 4 cycles, no idle cycle. o_data follows A,B,C,D,A; one o_done pulse per grant.
- Snapshot: grant requester 2 with word BEEF, change its i_data to 0000 mid-dwell → o_data stays BEEF until the next grant.
- Withdrawal: requester 1 granted and requester 3 pending; drop i_req[1] at dwell cycle 2 → next edge o_gnt=1000 with no o_done[1].
- Sole-requester refresh: only i_req[2] held, data changes 1111→2222 mid-dwell → at expiry o_done[2] pulses, requester 2 is re-granted, and o_data=2222.
- Async reset mid-dwell: assert rst_n low between clock edges → o_gnt and o_busy clear immediately, no o_done. After release, the first grant goes to the lowest-index requester.
